// File: rtl/conv_window_sched_if.sv
// Bundle between the layer controller/PE side and conv_window_sched.
// The master modport is the scheduler's view of the bundle.
interface conv_window_sched_if #(
    parameter int ADDR_W  = 10,
    parameter int WADDR_W = 5
);
    logic               start;
    logic               stall;
    logic               busy;
    logic               done;
    logic               pic_rd;
    logic [ADDR_W-1:0]  pic_addr;
    logic [WADDR_W-1:0] wgt_addr;
    logic               mac_en;
    logic               mac_clr;
    logic               mac_last;
    logic [7:0]         win_row;
    logic [7:0]         win_col;
    logic [15:0]        stall_cnt;
    logic [1:0]         dbg_state;

    // Handshake: start is a one-cycle request honoured only while idle; stall is
    // a not-ready level sampled only at window boundaries, never splitting a window.
    modport master (
        input  start, stall,
        output busy, done, pic_rd, pic_addr, wgt_addr, mac_en, mac_clr, mac_last,
               win_row, win_col, stall_cnt, dbg_state
    );

    modport slave (
        output start, stall,
        input  busy, done, pic_rd, pic_addr, wgt_addr, mac_en, mac_clr, mac_last,
               win_row, win_col, stall_cnt, dbg_state
    );
endinterface

// File: rtl/conv_window_sched.sv
// Convolution window read sequencer with MEM_LAT-aligned PE strobes.
// Optional stall performance counter enabled by defining CONV_SCHED_PERF_EN.
module conv_window_sched #(
    parameter int KNL     = 5,
    parameter int IMG_W   = 28,
    parameter int IMG_H   = 28,
    parameter int ADDR_W  = 10,
    parameter int WADDR_W = 5,
    parameter int MEM_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    conv_window_sched_if.master  bus
);
    localparam int OUT_W = IMG_W - KNL + 1;
    localparam int OUT_H = IMG_H - KNL + 1;
    localparam logic [7:0] K_MAX   = 8'(KNL - 1);
    localparam logic [7:0] COL_MAX = 8'(OUT_W - 1);
    localparam logic [7:0] ROW_MAX = 8'(OUT_H - 1);
    localparam logic [2:0] LAT_MAX = 3'(MEM_LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic       en;
        logic       clr;
        logic       last;
        logic [7:0] row;
        logic [7:0] col;
    } tap_t;

    state_t     state_q;
    logic [7:0] kc_q, kr_q, col_q, row_q;
    logic [7:0] kc_d, kr_d, col_d, row_d;
    logic [2:0] drain_q;
    tap_t       dl_q [MEM_LAT];
    tap_t       dl_d;

    logic boundary, issue, last_tap, last_win;

    assign boundary = (kr_q == 8'd0) && (kc_q == 8'd0);
    assign last_tap = (kr_q == K_MAX) && (kc_q == K_MAX);
    assign last_win = (row_q == ROW_MAX) && (col_q == COL_MAX);
    // Stall only bites at a window boundary so a window is always issued whole.
    assign issue    = (state_q == S_RUN) && !(boundary && bus.stall);

    always_comb begin
        kc_d  = kc_q;
        kr_d  = kr_q;
        col_d = col_q;
        row_d = row_q;
        if (kc_q == K_MAX) begin
            kc_d = 8'd0;
            if (kr_q == K_MAX) begin
                kr_d = 8'd0;
                if (col_q == COL_MAX) begin
                    col_d = 8'd0;
                    row_d = row_q + 8'd1;
                end else begin
                    col_d = col_q + 8'd1;
                end
            end else begin
                kr_d = kr_q + 8'd1;
            end
        end else begin
            kc_d = kc_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            kc_q    <= 8'd0;
            kr_q    <= 8'd0;
            col_q   <= 8'd0;
            row_q   <= 8'd0;
            drain_q <= 3'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q <= S_RUN;
                        kc_q    <= 8'd0;
                        kr_q    <= 8'd0;
                        col_q   <= 8'd0;
                        row_q   <= 8'd0;
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        kc_q  <= kc_d;
                        kr_q  <= kr_d;
                        col_q <= col_d;
                        row_q <= row_d;
                        if (last_tap && last_win) begin
                            state_q <= S_DRAIN;
                            drain_q <= 3'd0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_q == LAT_MAX) state_q <= S_DONE;
                    else                    drain_q <= drain_q + 3'd1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Delay line keeps PE strobes aligned with data returning from the memories.
    assign dl_d = '{en: issue, clr: issue && boundary, last: issue && last_tap,
                    row: row_q, col: col_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_LAT; i++) dl_q[i] <= '0;
        end else begin
            dl_q[0] <= dl_d;
            for (int i = 1; i < MEM_LAT; i++) dl_q[i] <= dl_q[i-1];
        end
    end

    assign bus.busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign bus.done      = (state_q == S_DONE);
    assign bus.pic_rd    = issue;
    assign bus.pic_addr  = ADDR_W'((32'(row_q) + 32'(kr_q)) * 32'(IMG_W) + 32'(col_q) + 32'(kc_q));
    assign bus.wgt_addr  = WADDR_W'(32'(kr_q) * 32'(KNL) + 32'(kc_q));
    assign bus.mac_en    = dl_q[MEM_LAT-1].en;
    assign bus.mac_clr   = dl_q[MEM_LAT-1].clr;
    assign bus.mac_last  = dl_q[MEM_LAT-1].last;
    assign bus.win_row   = dl_q[MEM_LAT-1].row;
    assign bus.win_col   = dl_q[MEM_LAT-1].col;
    assign bus.dbg_state = state_q;

`ifdef CONV_SCHED_PERF_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
        end else if ((state_q == S_IDLE) && bus.start) begin
            stall_cnt_q <= 16'd0;
        end else if ((state_q == S_RUN) && boundary && bus.stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`else
    assign bus.stall_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_conv_window_sched.sv
// Directed bench for conv_window_sched (KNL=3, 4x4 image) at MEM_LAT 1 and 3.
module tb_conv_window_sched;
    localparam int NTAPS = 36;
`ifdef CONV_SCHED_PERF_EN
    localparam int EXP_STALL = 3;
`else
    localparam int EXP_STALL = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic start, stall, sel;
    always #5 clk = ~clk;

    conv_window_sched_if #(.ADDR_W(4), .WADDR_W(4)) b1 ();
    conv_window_sched_if #(.ADDR_W(4), .WADDR_W(4)) b3 ();

    assign b1.start = start & ~sel;
    assign b3.start = start & sel;
    assign b1.stall = stall;
    assign b3.stall = stall;

    conv_window_sched #(.KNL(3), .IMG_W(4), .IMG_H(4), .ADDR_W(4), .WADDR_W(4), .MEM_LAT(1))
        dut1 (.clk(clk), .rst(rst), .bus(b1));
    conv_window_sched #(.KNL(3), .IMG_W(4), .IMG_H(4), .ADDR_W(4), .WADDR_W(4), .MEM_LAT(3))
        dut3 (.clk(clk), .rst(rst), .bus(b3));

    logic       m_rd, m_en, m_clr, m_last, m_busy, m_done;
    logic [3:0] m_addr, m_wgt;
    logic [7:0] m_row, m_col;
    logic [15:0] m_scnt;
    logic [1:0] m_state;

    always_comb begin
        m_rd    = sel ? b3.pic_rd    : b1.pic_rd;
        m_en    = sel ? b3.mac_en    : b1.mac_en;
        m_clr   = sel ? b3.mac_clr   : b1.mac_clr;
        m_last  = sel ? b3.mac_last  : b1.mac_last;
        m_busy  = sel ? b3.busy      : b1.busy;
        m_done  = sel ? b3.done      : b1.done;
        m_addr  = sel ? b3.pic_addr  : b1.pic_addr;
        m_wgt   = sel ? b3.wgt_addr  : b1.wgt_addr;
        m_row   = sel ? b3.win_row   : b1.win_row;
        m_col   = sel ? b3.win_col   : b1.win_col;
        m_scnt  = sel ? b3.stall_cnt : b1.stall_cnt;
        m_state = sel ? b3.dbg_state : b1.dbg_state;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: {pic_addr, wgt_addr} per issue and {clr, last, row, col} per PE tap
    logic [7:0]  exp_q[$];
    logic [17:0] mac_q[$];

    int cyc = 0, t0 = 0, lat = 1;
    int nb = 0, b_lo = -1, b_hi = -2, exp_done = 0;
    int rd_cnt = 0, done_cnt = 0, done_cyc = -1, last_rd_cyc = -1, last_mac_cyc = -1;
    int last_row = -1, last_col = -1;
    logic mon_on = 1'b0;

    function automatic logic rd_model(input int r);
        return (r >= 1) && (r <= NTAPS + nb) && !((r >= b_lo) && (r <= b_hi));
    endfunction

    task automatic setup_pass(input int l, input int bubbles, input int lo, input int hi);
        logic [7:0]  a;
        logic [17:0] m;
        lat = l; nb = bubbles; b_lo = lo; b_hi = hi;
        exp_done = NTAPS + nb + lat + 1;
        rd_cnt = 0; done_cnt = 0; done_cyc = -1; last_rd_cyc = -1; last_mac_cyc = -1;
        last_row = -1; last_col = -1;
        exp_q.delete();
        mac_q.delete();
        for (int wr = 0; wr < 2; wr++)
            for (int wc = 0; wc < 2; wc++)
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++) begin
                        a = {4'((wr + r) * 4 + wc + c), 4'(r * 3 + c)};
                        m = {(r == 0 && c == 0), (r == 2 && c == 2), 8'(wr), 8'(wc)};
                        exp_q.push_back(a);
                        mac_q.push_back(m);
                    end
    endtask

    // Cycle 0 is the cycle in which start is high; its closing edge samples start.
    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        t0 = cyc + 1;
        mon_on = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic to_cycle(input int k);
        while (cyc - t0 + 1 < k) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic finish_pass(input string tag);
        mon_on = 1'b0;
        chk(32'(exp_q.size()), 0, {tag, "_sb_addr_left"});
        chk(32'(mac_q.size()), 0, {tag, "_sb_mac_left"});
        chk(done_cnt, 1, {tag, "_done_count"});
        chk(done_cyc, exp_done, {tag, "_done_cycle"});
        chk(rd_cnt, NTAPS, {tag, "_rd_count"});
        chk(32'(m_state), 0, {tag, "_idle_after"});
    endtask

    always @(negedge clk) begin
        int rel;
        logic [7:0]  a;
        logic [17:0] m;
        cyc++;
        if (mon_on) begin
            rel = cyc - t0;
            chk(32'(m_rd), 32'(rd_model(rel)), "pic_rd");
            chk(32'(m_en), 32'(rd_model(rel - lat)), "mac_en");
            chk(32'(m_busy), 32'((rel >= 1) && (rel < exp_done)), "busy");
            chk(32'(m_done), 32'(rel == exp_done), "done");
            if (m_done) begin
                done_cnt++;
                done_cyc = rel;
            end
            if (m_rd) begin
                rd_cnt++;
                last_rd_cyc = rel;
                chk(32'(exp_q.size() > 0), 1, "sb_addr_underflow");
                if (exp_q.size() > 0) begin
                    a = exp_q.pop_front();
                    chk(32'(m_addr), 32'(a[7:4]), "pic_addr");
                    chk(32'(m_wgt), 32'(a[3:0]), "wgt_addr");
                end
            end
            if (m_en) begin
                last_mac_cyc = rel;
                chk(32'(mac_q.size() > 0), 1, "sb_mac_underflow");
                if (mac_q.size() > 0) begin
                    m = mac_q.pop_front();
                    chk(32'(m_clr), 32'(m[17]), "mac_clr");
                    chk(32'(m_last), 32'(m[16]), "mac_last");
                    if (m[16]) begin
                        chk(32'(m_row), 32'(m[15:8]), "win_row");
                        chk(32'(m_col), 32'(m[7:0]), "win_col");
                        last_row = int'(m_row);
                        last_col = int'(m_col);
                    end
                end
            end else begin
                chk(32'(m_clr | m_last), 0, "strobe_without_en");
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; stall = 1'b0; sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk(32'(b1.busy), 0, "rst_busy");
        chk(32'(b1.done), 0, "rst_done");
        chk(32'(b1.pic_rd), 0, "rst_pic_rd");
        chk(32'(b1.mac_en), 0, "rst_mac_en");
        chk(32'(b3.mac_en), 0, "rst_mac_en3");
        chk(32'(b1.stall_cnt), 0, "rst_stall_cnt");
        rst = 1'b0;

        // Plain pass with directed address / first-tap spot checks
        setup_pass(1, 0, -1, -2);
        pulse_start();
        to_cycle(18);
        chk(32'(b1.pic_addr), 11, "w01_tap22_addr");
        chk(32'(b1.wgt_addr), 8, "w01_tap22_wgt");
        to_cycle(28);
        chk(32'(b1.pic_addr), 5, "w11_first_addr");
        to_cycle(29);
        chk(32'(b1.mac_clr), 1, "w11_mac_clr");
        to_cycle(exp_done + 3);
        finish_pass("plain");

        // Stall mid-window (ignored) and for three cycles at the boundary of window 2
        setup_pass(1, 3, 19, 21);
        pulse_start();
        to_cycle(5);  stall = 1'b1;
        to_cycle(7);  stall = 1'b0;
        to_cycle(19); stall = 1'b1;
        to_cycle(22); stall = 1'b0;
        to_cycle(exp_done + 3);
        finish_pass("stall");
        chk(32'(b1.stall_cnt), EXP_STALL, "stall_cnt");

        // Start re-pulsed while running and during DONE
        setup_pass(1, 0, -1, -2);
        pulse_start();
        to_cycle(10); start = 1'b1;
        to_cycle(11); start = 1'b0;
        to_cycle(38); start = 1'b1;
        to_cycle(39); start = 1'b0;
        to_cycle(exp_done + 4);
        finish_pass("repulse");
        chk(32'(b1.stall_cnt), 0, "stall_cnt_cleared");

        // Asynchronous reset in the middle of a pass
        setup_pass(1, 0, -1, -2);
        pulse_start();
        to_cycle(20);
        mon_on = 1'b0;
        rst = 1'b1;
        #1;
        chk(32'(b1.busy), 0, "midrst_busy");
        chk(32'(b1.pic_rd), 0, "midrst_pic_rd");
        chk(32'(b1.pic_addr), 0, "midrst_pic_addr");
        chk(32'(b1.mac_en | b1.mac_clr | b1.mac_last), 0, "midrst_mac");
        chk(32'(b1.win_row | b1.win_col), 0, "midrst_win");
        chk(32'(b1.dbg_state), 0, "midrst_state");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk(32'(b1.done | b1.busy), 0, "post_rst_quiet");
        end
        setup_pass(1, 0, -1, -2);
        pulse_start();
        to_cycle(exp_done + 3);
        finish_pass("after_rst");

        // MEM_LAT=3 instance
        sel = 1'b1;
        setup_pass(3, 0, -1, -2);
        pulse_start();
        to_cycle(exp_done + 3);
        finish_pass("lat3");
        chk(last_rd_cyc, NTAPS, "lat3_last_rd");
        chk(last_mac_cyc, NTAPS + 3, "lat3_last_mac");
        chk(done_cyc - last_rd_cyc, 4, "lat3_done_gap");
        chk(last_row, 1, "lat3_final_row");
        chk(last_col, 1, "lat3_final_col");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/conv_window_sched.md
Name: conv_window_sched

Overview:
- Sequencer feeding one convolution MAC PE from a single-port feature-map memory and a weight memory.
- Walks every valid KNL x KNL window of an IMG_H x IMG_W image (stride 1, no padding) and issues one pixel/weight read pair per cycle.
- Delays the PE control strobes by the memory read latency so they arrive at the PE with the read data.
- Sits between the layer controller (start/done) and the PE plus its memories.

Parameters:
- KNL, 5, kernel edge length.
- IMG_W, 28, image width in pixels.
- IMG_H, 28, image height in pixels.
- ADDR_W, 10, feature-map address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- WADDR_W, 5, weight address width; must satisfy 2^WADDR_W >= KNL*KNL.
- MEM_LAT, 1, memory read latency in cycles; allowed range 1..4.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a layer pass.
- stall  in  1  downstream not ready; sampled only at window boundaries.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at end of pass.
- pic_rd  out  1  feature-map read strobe.
- pic_addr  out  ADDR_W  feature-map read address.
- wgt_addr  out  WADDR_W  weight read address; valid with pic_rd.
- mac_en  out  1  PE accumulate enable; pic_rd delayed by MEM_LAT.
- mac_clr  out  1  first tap of a window; delayed by MEM_LAT.
- mac_last  out  1  last tap of a window; delayed by MEM_LAT.
- win_row  out  8  output row of the window; valid when mac_last=1.
- win_col  out  8  output column of the window; valid when mac_last=1.
- stall_cnt  out  16  performance counter (see Optional Feature).

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all counters and the delay line cleared. Applies at any time, including mid-pass; no partial done.
- Derived sizes: OUT_W = IMG_W-KNL+1, OUT_H = IMG_H-KNL+1.
- Counters: kc (innermost, 0..KNL-1), kr, oc (0..OUT_W-1), orow (0..OUT_H-1, outermost).
- FSM states:
  - IDLE: start=1 -> RUN. busy=1 from the next cycle.
  - RUN, issue cycle:
    - Boundary cycle (kr=kc=0) with stall=1: no issue that cycle (pic_rd=0), counters hold.
    - Non-boundary cycle: stall is ignored, so a window is never split.
    - Each issue cycle: pic_rd=1, pic_addr=(orow+kr)*IMG_W+(oc+kc), wgt_addr=kr*KNL+kc, then advance counters.
  - RUN -> DRAIN after the last tap of window (OUT_H-1, OUT_W-1) is issued.
  - DRAIN: MEM_LAT cycles, pic_rd=0, delay line flushes.
  - DONE: done=1 for one cycle, busy=0 in this cycle -> IDLE.
- Delay line: MEM_LAT-deep shift register carrying {pic_rd, first-tap, last-tap, orow, oc}. Shifts every cycle; bubbles propagate as mac_en=0.
- mac_clr and mac_last are each asserted only together with mac_en.
- KNL=1: mac_clr and mac_last are both high on the same tap.
- start while busy, or during DRAIN/DONE: ignored, no restart.
- Address arithmetic is performed at full width, then truncated to ADDR_W; the parameter constraints guarantee no wrap.
- Throughput without stalls: KNL*KNL cycles per output pixel.
- Total cycles from the start-sampling edge to done: OUT_H*OUT_W*KNL*KNL + (stall bubbles) + MEM_LAT + 1.

Optional Feature:
- Macro: CONV_SCHED_PERF_EN.
- Defined: stall_cnt counts cycles in RUN where stall blocked an issue. It saturates at 0xFFFF, clears when start is accepted, and holds after done.
- Undefined: stall_cnt is tied to 0 and the counter logic is absent.

Test Plan:
- KNL=3, IMG_W=IMG_H=4, MEM_LAT=1, start pulse, stall=0 -> pic_rd high cycles 1..36, 4 windows x 9 taps; done=1 at cycle 38 only; busy high cycles 1..37.
- Same config, window (0,1) tap kr=2,kc=2 -> pic_addr=11, wgt_addr=8. Window (1,1) first tap -> pic_addr=5, mac_clr=1 one cycle later.
- stall=1 held for 3 cycles at the boundary before window 2 -> three pic_rd=0 bubbles; stall asserted mid-window has no effect; done at cycle 41; stall_cnt=3 with CONV_SCHED_PERF_EN defined, 0 without.
- MEM_LAT=3 -> mac_en/mac_clr/mac_last lag pic_rd by exactly 3 cycles; win_row/win_col = (1,1) with the final mac_last; done 4 cycles after the last pic_rd.
- rst asserted at cycle 20 of a pass -> all outputs 0 immediately; no done. A new start after rst release runs a full 36-tap pass.
- start re-pulsed at cycle 10 and again during DONE -> ignored; exactly one done pulse; FSM returns to IDLE.
